// File: rtl/wsg_pkg.sv
// Shared WSG constants, the DAC byte layout and the PCM sample type.
// Used by the mixer, the optional IIR stage and the audio output stage.
package wsg_pkg;

    localparam int                    PHASE_BITS   = 7;
    localparam logic [3:0]            CAPTURE_NIB  = 4'hC;
    localparam logic [PHASE_BITS-1:0] LAST_CAPTURE = 7'h7C;
    localparam logic [PHASE_BITS-1:0] OUT_PHASE    = 7'h7D;
    localparam logic [7:0]            WAVE_BIAS    = 8'd8;

    typedef logic signed [15:0] sample_t;

    typedef struct packed {
        logic [3:0] vol;
        logic [3:0] wave;
    } dac_byte_t;

    // Products lie in -120..105, so eight bits hold them without loss.
    function automatic logic signed [7:0] slot_product(input dac_byte_t b);
        logic signed [7:0] s;
        logic signed [7:0] v;
        s = $signed({4'b0000, b.wave} - WAVE_BIAS);
        v = $signed({4'b0000, b.vol});
        return s * v;
    endfunction

endpackage

// File: rtl/wsg_lpf.sv
// One-pole IIR low-pass (y += (x - y) >>> 3) modelling the board RC filter.
// Latency: y_dat updates on the edge where upd_vld is high.
// Backpressure: none; one update per frame, no stall path.
import wsg_pkg::*;

module wsg_lpf (
    input  logic               pxclk,
    input  logic               RESET,
    input  logic               upd_vld,
    input  logic signed [15:0] x_dat,
    output logic signed [15:0] y_dat
);

    logic signed [16:0] diff;
    logic signed [16:0] step;
    sample_t            y_nxt;

    // 17-bit difference so full-scale steps cannot wrap before the shift.
    assign diff  = {x_dat[15], x_dat} - {y_dat[15], y_dat};
    assign step  = diff >>> 3;
    assign y_nxt = y_dat + 16'(step);

    always_ff @(posedge pxclk or posedge RESET) begin
        if (RESET) begin
            y_dat <= '0;
        end else if (upd_vld) begin
            y_dat <= y_nxt;
        end
    end

endmodule

// File: rtl/wsg_mixer.sv
// Mixes the 8 time-multiplexed WSG slots into one signed PCM sample per 128-clock frame; MIXER_LPF_EN adds the IIR stage.
// Latency: sample_out updates 1 cycle after slot 7 capture (113 after slot 0); sample_valid pulses for 1 cycle.
// Backpressure: none; free-running, the consumer must take every sample_valid pulse.
import wsg_pkg::*;

module wsg_mixer #(
    parameter int OUT_SHIFT = 5
) (
    input  logic               pxclk,
    input  logic               RESET,
    input  logic [7:0]         c99raw_in,
    input  logic               mute,
    output logic signed [15:0] sample_out,
    output logic               sample_valid,
    output logic [2:0]         frame_slot
);

    logic [PHASE_BITS-1:0] phase;
    dac_byte_t             dac_dat;
    logic                  capture;
    logic                  out_en;
    logic signed [7:0]     prod;
    logic signed [10:0]    prod_ext;
    logic signed [10:0]    acc;
    logic signed [10:0]    acc_sum;
    logic signed [10:0]    sum_r;
    sample_t               sum_ext;
    sample_t               x;

    assign dac_dat    = c99raw_in;
    assign capture    = (phase[3:0] == CAPTURE_NIB);
    assign out_en     = (phase == OUT_PHASE);
    assign frame_slot = phase[6:4];

    assign prod     = slot_product(dac_dat);
    assign prod_ext = {{3{prod[7]}}, prod};
    assign acc_sum  = acc + prod_ext;

    // Frame sum stays within -960..840, so 11 bits never overflow.
    assign sum_ext = {{5{sum_r[10]}}, sum_r};
    assign x       = mute ? '0 : (sum_ext <<< OUT_SHIFT);

    always_ff @(posedge pxclk or posedge RESET) begin
        if (RESET) begin
            phase        <= '0;
            acc          <= '0;
            sum_r        <= '0;
            sample_valid <= 1'b0;
        end else begin
            phase        <= phase + 7'd1;
            sample_valid <= out_en;
            // Slot 0 overwrites the accumulator, which restarts the frame.
            if (capture) begin
                acc <= (phase[6:4] == 3'd0) ? prod_ext : acc_sum;
            end
            if (phase == LAST_CAPTURE) begin
                sum_r <= acc_sum;
            end
        end
    end

`ifdef MIXER_LPF_EN
    wsg_lpf u_lpf (
        .pxclk   (pxclk),
        .RESET   (RESET),
        .upd_vld (out_en),
        .x_dat   (x),
        .y_dat   (sample_out)
    );
`else
    always_ff @(posedge pxclk or posedge RESET) begin
        if (RESET) begin
            sample_out <= '0;
        end else if (out_en) begin
            sample_out <= x;
        end
    end
`endif

endmodule

// File: tb/tb_wsg_mixer.sv
// Self-checking bench for wsg_mixer: frame-level model plus directed literal checks.
module tb_wsg_mixer;

    localparam int OUT_SHIFT = 5;

    logic               pxclk = 1'b0;
    logic               RESET = 1'b1;
    logic [7:0]         c99raw_in = 8'h08;
    logic               mute = 1'b0;
    logic signed [15:0] sample_out;
    logic               sample_valid;
    logic [2:0]         frame_slot;

    wsg_mixer #(.OUT_SHIFT(OUT_SHIFT)) dut (
        .pxclk        (pxclk),
        .RESET        (RESET),
        .c99raw_in    (c99raw_in),
        .mute         (mute),
        .sample_out   (sample_out),
        .sample_valid (sample_valid),
        .frame_slot   (frame_slot)
    );

    always #5 pxclk = ~pxclk;

    int checks = 0;
    int errors = 0;

    logic [6:0] ph = 7'd0;
    logic [7:0] cur_bytes [8];
    logic [7:0] cap [8];
    int exp_hold = 0;
    int pending  = 0;
    int y_m      = 0;

    // Frame position as the spec defines it: 0 after reset, +1 per clock.
    always @(posedge pxclk or posedge RESET) begin
        if (RESET) ph <= 7'd0;
        else       ph <= ph + 7'd1;
    end

    task automatic chk(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int frame_model();
        int sum = 0;
        int x;
        int d;
        for (int i = 0; i < 8; i++)
            sum += int'(cap[i][7:4]) * (int'(cap[i][3:0]) - 8);
        x = mute ? 0 : sum * (1 << OUT_SHIFT);
`ifdef MIXER_LPF_EN
        d = x - y_m;
        y_m = y_m + ((d >= 0) ? d / 8 : -((-d + 7) / 8));
        return y_m;
`else
        return x;
`endif
    endfunction

    // WSG emulation: slot k byte appears after the edge at phase k*16+8.
    initial begin
        forever begin
            @(posedge pxclk);
            #1;
            if (!RESET && ph[3:0] == 4'h9) c99raw_in = cur_bytes[ph[6:4]];
        end
    end

    // Continuous compare against the frame model.
    initial begin
        forever begin
            @(negedge pxclk);
            if (RESET) begin
                exp_hold = 0;
                pending  = 0;
                y_m      = 0;
            end else begin
                if (ph == 7'h7E) exp_hold = pending;
                chk("valid", sample_valid, ph == 7'h7E);
                chk("sample", sample_out, exp_hold);
                chk("slot", frame_slot, ph[6:4]);
                if (ph[3:0] == 4'hC) cap[ph[6:4]] = c99raw_in;
                if (ph == 7'h7D) pending = frame_model();
            end
        end
    end

    task automatic wait_pulse(output int n);
        n = 0;
        do begin
            @(negedge pxclk);
            n++;
        end while (!sample_valid && n < 300);
        chk("pulse_seen", sample_valid, 1);
    endtask

    task automatic set_all(input logic [7:0] b);
        for (int i = 0; i < 8; i++) cur_bytes[i] = b;
    endtask

    int n;
    int k;
    int prev;

    initial begin
        set_all(8'h08);
        repeat (2) @(negedge pxclk);
        chk("reset_sample", sample_out, 0);
        chk("reset_valid", sample_valid, 0);
        chk("reset_slot", frame_slot, 0);
        #2 RESET = 1'b0;

        wait_pulse(n);
        chk("first_gap", n, 126);
        chk("idle_sample", sample_out, 0);
        for (int i = 0; i < 2; i++) begin
            wait_pulse(n);
            chk("period", n, 128);
            chk("idle_sample", sample_out, 0);
        end

`ifndef MIXER_LPF_EN
        set_all(8'h08);
        cur_bytes[2] = 8'hFF;
        wait_pulse(n);
        chk("slot2_only", sample_out, 3360);

        set_all(8'hF0);
        wait_pulse(n);
        chk("all_min", sample_out, -30720);

        set_all(8'hFF);
        wait_pulse(n);
        chk("all_max", sample_out, 26880);

        mute = 1'b1;
        wait_pulse(n);
        chk("mute_period", n, 128);
        chk("muted", sample_out, 0);

        mute = 1'b0;
        wait_pulse(n);
        chk("unmuted", sample_out, 26880);
`else
        set_all(8'hFF);
        wait_pulse(n);
        chk("lpf_first", sample_out, 3360);
`endif

        k = 0;
        while (ph != 7'h45 && k < 300) begin
            @(negedge pxclk);
            k++;
        end
        chk("reach_45", ph, 7'h45);
        #2 RESET = 1'b1;
        #1;
        chk("arst_sample", sample_out, 0);
        chk("arst_valid", sample_valid, 0);
        chk("arst_slot", frame_slot, 0);
        repeat (2) @(negedge pxclk);
        #2 RESET = 1'b0;

        wait_pulse(n);
        chk("post_reset_gap", n, 126);
`ifndef MIXER_LPF_EN
        chk("post_reset_val", sample_out, 26880);
`else
        chk("lpf_step1", sample_out, 3360);
        wait_pulse(n);
        chk("lpf_step2", sample_out, 6300);
        wait_pulse(n);
        chk("lpf_step3", sample_out, 8872);
        prev = sample_out;
        for (int i = 0; i < 4; i++) begin
            wait_pulse(n);
            chk("lpf_rising", (sample_out > prev) && (sample_out <= 26880), 1);
            prev = sample_out;
        end
`endif

        repeat (4) @(negedge pxclk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
